// File: rtl/rc4_stream_xor.sv
// rtl/rc4_stream_xor.sv - sequences the RC4 core per message and XORs a byte stream with its keystream
module rc4_stream_xor #(
  parameter int NUMS_OF_BYTES = 4,
  parameter int CORE_TIMEOUT  = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [7:0]                 msg_len,
  output logic                       core_rst_n,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic [NUMS_OF_BYTES*8-1:0] core_ckey,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       msg_done,
  output logic                       timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_CORE_RST, S_CORE_RUN, S_STREAM, S_DONE} state_t;

  state_t                     r_state, w_state_next;
  logic [7:0]                 r_len, r_byte_cnt;
  logic [31:0]                r_timer;
  logic [NUMS_OF_BYTES*8-1:0] r_ks;
  logic [7:0]                 r_out_data, w_ks_byte, w_len_clamped;
  logic                       r_out_valid, r_core_rst_n, r_core_start, r_msg_done, r_timeout_err;
  logic                       w_out_free, w_in_ready, w_accept, w_timeout;

  assign w_out_free    = !r_out_valid || out_ready;
  assign w_in_ready    = (r_state == S_STREAM) && (r_byte_cnt < r_len) && w_out_free;
  assign w_accept      = in_valid && w_in_ready;
  assign w_timeout     = (CORE_TIMEOUT != 0) && (r_timer + 32'd1 == 32'(CORE_TIMEOUT));
  assign w_len_clamped = (msg_len > 8'(NUMS_OF_BYTES)) ? 8'(NUMS_OF_BYTES) : msg_len;

  always_comb begin
    w_ks_byte = '0;
    for (int b = 0; b < NUMS_OF_BYTES; b++) begin
      if (r_byte_cnt == 8'(b)) w_ks_byte = r_ks[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // core_done wins over the timeout when both land in the same cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (go) w_state_next = S_CORE_RST;
      S_CORE_RST: w_state_next = S_CORE_RUN;
      S_CORE_RUN: begin
        if (core_done)      w_state_next = S_STREAM;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_STREAM:   if ((r_byte_cnt == r_len) && w_out_free) w_state_next = S_DONE;
      S_DONE:     w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_rst_n  <= 1'b0;
      r_core_start  <= 1'b0;
      r_msg_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timer       <= '0;
      r_len         <= '0;
      r_byte_cnt    <= '0;
      r_ks          <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
    end else begin
      r_core_rst_n  <= (w_state_next != S_CORE_RST);
      r_core_start  <= (w_state_next == S_CORE_RUN);
      r_msg_done    <= (w_state_next == S_DONE);
      r_timeout_err <= (r_state == S_CORE_RUN) && !core_done && w_timeout;
      r_timer       <= (r_state == S_CORE_RUN) ? r_timer + 32'd1 : 32'd0;
      if (r_state == S_IDLE && go) r_len <= w_len_clamped;
      if (r_state == S_CORE_RUN && core_done) begin
        r_ks       <= core_ckey;
        r_byte_cnt <= '0;
      end
      // a new accept refills the register in the same cycle it drains
      if (w_accept) begin
        r_out_data  <= in_data ^ w_ks_byte;
        r_out_valid <= 1'b1;
        r_byte_cnt  <= r_byte_cnt + 8'd1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign core_rst_n  = r_core_rst_n;
  assign core_start  = r_core_start;
  assign in_ready    = w_in_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign busy        = (r_state != S_IDLE);
  assign msg_done    = r_msg_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_rc4_stream_xor.sv
// tb/tb_rc4_stream_xor.sv - directed self-checking bench for rc4_stream_xor
module tb_rc4_stream_xor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  msg_len = '0;
  logic        core_rst_n, core_start;
  logic        core_done = 1'b0;
  logic [31:0] core_ckey = 32'hA3B2C1D0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, msg_done, timeout_err;

  rc4_stream_xor #(.NUMS_OF_BYTES(4), .CORE_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .go(go), .msg_len(msg_len),
    .core_rst_n(core_rst_n), .core_start(core_start),
    .core_done(core_done), .core_ckey(core_ckey),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .msg_done(msg_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // core model: done rises after 10 cycles of start, sticky until core reset
  logic never_done = 1'b0;
  int   core_cnt = 0;
  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else if (core_start && !core_done) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 9 && !never_done) core_done <= 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;

  logic [7:0] vec [0:8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
  logic [7:0] exp_ct [0:3] = '{8'hC1, 8'hE3, 8'h81, 8'hE7};

  logic [7:0] got [$];
  int         got_cyc [$];
  int         consumed, done_pulses, tmo_pulses, rstn_low, start_high;
  int         last_start_cyc, done_cyc, cyc;
  bit         stall_bad, finished;

  task automatic start_msg(input logic [7:0] len);
    @(negedge clk);
    go = 1'b1;
    msg_len = len;
  endtask

  task automatic run_stream(input int n_avail, input int stall_len, input int stop_after, input int budget);
    int idx, stall_left;
    bit seen_first;
    logic [7:0] first_byte;
    got.delete(); got_cyc.delete();
    idx = 0; stall_left = 0; seen_first = 0; first_byte = '0;
    done_pulses = 0; tmo_pulses = 0; rstn_low = 0; start_high = 0;
    last_start_cyc = 0; done_cyc = 0; cyc = 0; stall_bad = 0; finished = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      go = 1'b0;
      cyc++;
      if (stop_after > 0 && idx >= stop_after) begin
        finished = 1;
        break;
      end
      if (out_valid && !seen_first) begin
        seen_first = 1;
        stall_left = stall_len;
        first_byte = out_data;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_valid = (idx < n_avail);
      in_data  = (idx < n_avail) ? vec[idx] : 8'h00;
      #1;
      if (!out_ready && out_valid && (in_ready !== 1'b0 || out_data !== first_byte)) stall_bad = 1;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) idx++;
      if (!core_rst_n) rstn_low++;
      if (core_start) begin
        start_high++;
        last_start_cyc = cyc;
      end
      if (timeout_err) begin
        tmo_pulses++;
        finished = 1;
      end
      if (msg_done) begin
        done_pulses++;
        done_cyc = cyc;
        finished = 1;
      end
      if (finished) break;
    end
    consumed = idx;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({core_rst_n, core_start, out_valid, msg_done, timeout_err, busy, in_ready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {core_rst_n, core_start, out_valid, msg_done, timeout_err, busy, in_ready});
    end
    checks++;
    if (out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_out_data got=%h exp=00", out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (core_rst_n !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got rstn=%b busy=%b exp rstn=1 busy=0", core_rst_n, busy);
    end
  endtask

  task automatic test_full_message(input string tag, input int stall_len, input int n_avail, input logic [7:0] len);
    start_msg(len);
    run_stream(n_avail, stall_len, 0, 200);
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s_timeout got=no_msg_done exp=msg_done", tag);
    end
    checks++;
    if (got.size() != 4 || consumed != 4) begin
      failures++;
      $display("FAIL %s_count got out=%0d consumed=%0d exp 4/4", tag, got.size(), consumed);
    end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_ct[i]) begin
        failures++;
        $display("FAIL %s_byte%0d got=%h exp=%h", tag, i, got[i], exp_ct[i]);
      end
    end
    checks++;
    if (rstn_low != 1 || done_pulses != 1 || tmo_pulses != 0) begin
      failures++;
      $display("FAIL %s_ctrl got rstn_low=%0d done=%0d tmo=%0d exp 1/1/0", tag, rstn_low, done_pulses, tmo_pulses);
    end
    if (stall_len == 0 && got_cyc.size() == 4) begin
      checks++;
      if (got_cyc[3] - got_cyc[0] != 3) begin
        failures++;
        $display("FAIL %s_throughput got span=%0d exp=3", tag, got_cyc[3] - got_cyc[0]);
      end
    end
    if (stall_len > 0) begin
      checks++;
      if (stall_bad) begin
        failures++;
        $display("FAIL %s_stall_hold got=unstable_or_ready exp=held_not_ready", tag);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || msg_done !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle got busy=%b done=%b in_ready=%b exp 0/0/0", tag, busy, msg_done, in_ready);
    end
  endtask

  task automatic test_zero_len();
    start_msg(8'd0);
    run_stream(4, 0, 0, 200);
    checks++;
    if (consumed != 0 || got.size() != 0 || done_pulses != 1 || rstn_low != 1) begin
      failures++;
      $display("FAIL zero_len got consumed=%0d out=%0d done=%0d rstn_low=%0d exp 0/0/1/1",
               consumed, got.size(), done_pulses, rstn_low);
    end
    checks++;
    if (done_cyc - last_start_cyc != 2) begin
      failures++;
      $display("FAIL zero_len_latency got=%0d exp=2", done_cyc - last_start_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    never_done = 1'b1;
    start_msg(8'd4);
    run_stream(4, 0, 0, 200);
    checks++;
    if (tmo_pulses != 1 || done_pulses != 0 || consumed != 0) begin
      failures++;
      $display("FAIL timeout_pulse got tmo=%0d done=%0d consumed=%0d exp 1/0/0", tmo_pulses, done_pulses, consumed);
    end
    checks++;
    if (start_high != 20) begin
      failures++;
      $display("FAIL timeout_cycles got=%0d exp=20", start_high);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle got busy=%b exp=0", busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_one_cycle got=%b exp=0", timeout_err);
    end
    never_done = 1'b0;
    test_full_message("after_timeout", 0, 4, 8'd4);
  endtask

  task automatic test_reset_mid_stream();
    start_msg(8'd4);
    run_stream(4, 0, 2, 200);
    checks++;
    if (consumed != 2) begin
      failures++;
      $display("FAIL midrst_progress got consumed=%0d exp=2", consumed);
    end
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || core_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort got busy=%b out_valid=%b rstn=%b exp 0/0/0", busy, out_valid, core_rst_n);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    test_full_message("after_rst", 0, 4, 8'd4);
  endtask

  initial begin
    test_reset();
    test_full_message("basic", 0, 4, 8'd4);
    test_full_message("stall", 3, 4, 8'd4);
    test_full_message("clamp", 0, 9, 8'd9);
    test_zero_len();
    test_timeout();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
